// File: rtl/muxn_pkg.sv
// rtl/muxn_pkg.sv - shared types, mode constants and width helper for the stream mux
package muxn_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } muxn_state_t;

  localparam int MUXN_MODE_SEL = 0;
  localparam int MUXN_MODE_RR  = 1;

  // Width of a channel index; a single channel still gets a 1-bit index port.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching ptr+1 .. ptr+N
module rr_arbiter
  import muxn_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int cand;

  // Walk the channels starting just after the last winner; first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!gnt_any && req[cand]) begin
        gnt_any       = 1'b1;
        gnt[cand]     = 1'b1;
        gnt_idx       = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/muxn_stream_arb.sv
// rtl/muxn_stream_arb.sv - N-channel registered stream mux with packet lock and select or round-robin grant
module muxn_stream_arb
  import muxn_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = MUXN_MODE_SEL,
  localparam int SELW = sel_width(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N*W-1:0]  I,
  input  logic [N-1:0]    I_VALID,
  input  logic [N-1:0]    I_LAST,
  output logic [N-1:0]    I_READY,
  input  logic [SELW-1:0] S,
  output logic [W-1:0]    Z,
  output logic            Z_VALID,
  output logic            Z_LAST,
  output logic [SELW-1:0] Z_SEL,
  input  logic            Z_READY
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_LOCKED = LOCKED;

  logic [0:0]      state;
  logic [SELW-1:0] lock_ch;
  logic [SELW-1:0] rr_ptr;

  logic [N-1:0]    arb_gnt;
  logic [SELW-1:0] arb_idx;
  logic            arb_any;

  logic [N-1:0]    grant_vec;
  logic [SELW-1:0] grant_idx;
  logic            ld_en;
  logic            xfer;
  logic [W-1:0]    sel_data;
  logic            sel_last;

  rr_arbiter #(.N(N)) u_arb (
    .req     (I_VALID),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // The output register can take a new beat when empty or being drained this cycle.
  assign ld_en = !Z_VALID | Z_READY;

  // One-hot grant: locked channel wins outright, otherwise select port or arbiter.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    if (state == ST_LOCKED) begin
      grant_idx = lock_ch;
      for (int k = 0; k < N; k++) begin
        grant_vec[k] = (lock_ch == SELW'(k));
      end
    end else if (MODE == MUXN_MODE_RR) begin
      grant_idx = arb_idx;
      grant_vec = arb_any ? arb_gnt : '0;
    end else begin
      // An out-of-range select matches no channel, so nothing is granted.
      grant_idx = S;
      for (int k = 0; k < N; k++) begin
        grant_vec[k] = (S == SELW'(k));
      end
    end
  end

  assign I_READY = (ld_en && !RST) ? grant_vec : '0;
  assign xfer    = |(I_READY & I_VALID);

  // Steer the granted channel's data and end marker toward the output register.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant_vec[k]) begin
        sel_data = I[k*W +: W];
        sel_last = I_LAST[k];
      end
    end
  end

  // Packet lock: enter on a non-final beat, leave on the final one; advance round-robin per packet.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
      rr_ptr  <= SELW'(N - 1);
    end else if (xfer) begin
      if (sel_last) begin
        state <= ST_IDLE;
        if (MODE == MUXN_MODE_RR) begin
          rr_ptr <= grant_idx;
        end
      end else begin
        state   <= ST_LOCKED;
        lock_ch <= grant_idx;
      end
    end
  end

  // Output register: load on transfer, empty when loadable with nothing to load, else hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Z       <= '0;
      Z_VALID <= 1'b0;
      Z_LAST  <= 1'b0;
      Z_SEL   <= '0;
    end else if (ld_en) begin
      Z_VALID <= xfer;
      if (xfer) begin
        Z      <= sel_data;
        Z_LAST <= sel_last;
        Z_SEL  <= grant_idx;
      end
    end
  end

endmodule
